alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator side of the ALU operand/command interface.
- Accepts one command packet at a time from an upstream valid/ready channel and drives it into the registered ALU for exactly one CE cycle.
- Waits the ALU's fixed latency, captures the result and the six status flags, and returns them with a sequence tag on a downstream valid/ready channel.
- Keeps wrapping operation and error counters for software and debug visibility.

Parameters:
WIDTH, 8, operand width; must match the ALU instance.
ALU_LAT, 1, ALU clock edges from the CE-high edge to valid outputs; legal range 1..15.
TAG_W, 4, width of the response sequence tag.
CNT_W, 16, width of the operation and error counters.

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
req_valid  in  1  upstream command valid
req_ready  out  1  high only in IDLE
req_mode  in  1  1 = arithmetic, 0 = logical
req_cmd  in  4  ALU command code (shared defines)
req_inp_valid  in  2  operand-valid bits {A,B}
req_opa  in  WIDTH  operand A
req_opb  in  WIDTH  operand B
req_cin  in  1  carry in
ALU_CE  out  1  ALU clock enable
ALU_MODE  out  1  registered copy of req_mode
ALU_CMD  out  4  registered copy of req_cmd
ALU_INP_VALID  out  2  registered copy of req_inp_valid
ALU_OPA  out  WIDTH  registered copy of req_opa
ALU_OPB  out  WIDTH  registered copy of req_opb
ALU_CIN  out  1  registered copy of req_cin
ALU_RES  in  2*WIDTH+1  ALU result
ALU_FLAGS  in  6  ALU {ERR,OFLOW,COUT,G,L,E}
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream ready
rsp_res  out  2*WIDTH+1  captured result
rsp_flags  out  6  captured {ERR,OFLOW,COUT,G,L,E}
rsp_tag  out  TAG_W  sequence tag of this response
op_cnt  out  CNT_W  completed operations
err_cnt  out  CNT_W  completed operations with ERR=1

Behaviour:
- Reset (RST=1, asynchronous):
  - state=IDLE; ALU_CE=0; all ALU_* outputs 0.
  - rsp_valid=0, rsp_res=0, rsp_flags=0.
  - Tag register, op_cnt and err_cnt = 0.
  - Reset in any state aborts the in-flight operation; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch all req_* fields into the ALU_* output registers, then go to ISSUE.
- ISSUE: one cycle, ALU_CE=1, then go to WAIT with the latency counter loaded to ALU_LAT.
- WAIT:
  - ALU_CE=0; the counter decrements each edge.
  - At the edge where the counter equals 1, capture ALU_RES into rsp_res and ALU_FLAGS into rsp_flags.
  - On that same edge: op_cnt+=1, err_cnt+=1 if ALU_FLAGS[5], go to RESP.
- RESP:
  - rsp_valid=1; rsp_res, rsp_flags and rsp_tag are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: tag+=1 and go to IDLE.
- ALU_CE is high only in ISSUE.
- ALU_* data outputs hold their last latched values in every other state, so the ALU outputs stay frozen.
- Latency: rsp_valid rises ALU_LAT+1 edges after the accepting edge.
- Throughput: at most one operation per ALU_LAT+3 cycles.
- No back-to-back acceptance: req_ready stays 0 in the RESP handshake cycle.
- Wrap rules:
  - Tag, op_cnt and err_cnt wrap modulo 2^TAG_W or 2^CNT_W; no saturation.
  - At all-ones, op_cnt and err_cnt go to 0 on the next increment.
- No payload checking: the block never inspects or alters cmd/inp_valid legality. ALU-reported ERR (e.g. INP_VALID=00) passes through unchanged.
- req_* values presented while req_ready=0 are ignored.
- Upstream must not change req_* while req_valid=1 and req_ready=0.

Test Plan:
- Carry out: mode=1, cmd=ADD, inp_valid=11, opa=0xFF, opb=0x01, ALU_LAT=1; accept at edge N
  -> ALU_CE high for the one cycle after N; rsp_valid at edge N+2; rsp_res=0x100; rsp_flags=6'b001000; rsp_tag=0; op_cnt=1.
- Backpressure: same op with rsp_ready held 0 for 5 cycles
  -> rsp_valid, rsp_res and rsp_flags stable all 5 cycles; req_ready=0 throughout; after the handshake, tag=1 and req_ready=1 next cycle.
- Error path: inp_valid=00, cmd=ADD
  -> rsp_flags[5]=1; rsp_res=0; err_cnt increments to 1; op_cnt increments.
- Compare: mode=1, cmd=CMP, opa=0x10, opb=0x20 -> rsp_flags=6'b000010 (L=1).
- Mid-operation reset: assert RST in WAIT
  -> immediately ALU_CE=0, rsp_valid=0, counters=0; no response emitted; the next request gets tag=0.
- Latency and wrap: run 17 ops with ALU_LAT=3, TAG_W=4
  -> each rsp_valid arrives 4 edges after acceptance; rsp_tag sequence 0..15 then 0; ALU_CE pulses exactly 17 times.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Initiator for the registered ALU: takes one command from the request channel,
// pulses ALU_CE once, waits out the ALU latency and returns result, flags and tag.
module alu_cmd_driver #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_mode,
    input  logic [3:0]           req_cmd,
    input  logic [1:0]           req_inp_valid,
    input  logic [WIDTH-1:0]     req_opa,
    input  logic [WIDTH-1:0]     req_opb,
    input  logic                 req_cin,

    output logic                 ALU_CE,
    output logic                 ALU_MODE,
    output logic [3:0]           ALU_CMD,
    output logic [1:0]           ALU_INP_VALID,
    output logic [WIDTH-1:0]     ALU_OPA,
    output logic [WIDTH-1:0]     ALU_OPB,
    output logic                 ALU_CIN,
    input  logic [2*WIDTH:0]     ALU_RES,
    input  logic [5:0]           ALU_FLAGS,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH:0]     rsp_res,
    output logic [5:0]           rsp_flags,
    output logic [TAG_W-1:0]     rsp_tag,

    output logic [CNT_W-1:0]     op_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] lat_cnt;
    logic [TAG_W-1:0] tag_q;

    assign req_ready = (state == IDLE);
    assign rsp_tag   = tag_q;

    // ALU_* data registers are only written on acceptance, so the ALU inputs
    // stay frozen for the whole operation and afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            tag_q         <= '0;
            ALU_CE        <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CMD       <= '0;
            ALU_INP_VALID <= '0;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            ALU_CIN       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_res       <= '0;
            rsp_flags     <= '0;
            op_cnt        <= '0;
            err_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ALU_MODE      <= req_mode;
                        ALU_CMD       <= req_cmd;
                        ALU_INP_VALID <= req_inp_valid;
                        ALU_OPA       <= req_opa;
                        ALU_OPB       <= req_opb;
                        ALU_CIN       <= req_cin;
                        ALU_CE        <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    ALU_CE  <= 1'b0;
                    lat_cnt <= 4'(ALU_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    // Counter reaches 1 on the edge after ALU outputs became valid.
                    if (lat_cnt == 4'd1) begin
                        rsp_res   <= ALU_RES;
                        rsp_flags <= ALU_FLAGS;
                        rsp_valid <= 1'b1;
                        op_cnt    <= op_cnt + CNT_W'(1);
                        if (ALU_FLAGS[5])
                            err_cnt <= err_cnt + CNT_W'(1);
                        state     <= RESP;
                    end
                    lat_cnt <= lat_cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        tag_q     <= tag_q + TAG_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each fed by a small behavioural ALU model.
module tb_alu_cmd_driver;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Instance with ALU_LAT=1
    logic        req_valid = 1'b0, req_ready, req_mode = 1'b0, req_cin = 1'b0;
    logic [3:0]  req_cmd = '0;
    logic [1:0]  req_inp_valid = '0;
    logic [7:0]  req_opa = '0, req_opb = '0;
    logic        alu_ce, alu_mode, alu_cin;
    logic [3:0]  alu_cmd;
    logic [1:0]  alu_inp_valid;
    logic [7:0]  alu_opa, alu_opb;
    logic [16:0] alu_res = '0;
    logic [5:0]  alu_flags = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [16:0] rsp_res;
    logic [5:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic [15:0] op_cnt, err_cnt;

    // Instance with ALU_LAT=3, always issuing ADD of opa+1
    logic        l3_req_valid = 1'b0, l3_req_ready;
    logic [7:0]  l3_req_opa = '0;
    logic        l3_ce, l3_mode, l3_cin;
    logic [3:0]  l3_cmd;
    logic [1:0]  l3_inp_valid;
    logic [7:0]  l3_opa, l3_opb;
    logic [22:0] l3_s0 = '0, l3_s1 = '0, l3_s2 = '0;
    logic        l3_rsp_valid, l3_rsp_ready = 1'b1;
    logic [16:0] l3_rsp_res;
    logic [5:0]  l3_rsp_flags;
    logic [3:0]  l3_rsp_tag;
    logic [15:0] l3_op_cnt, l3_err_cnt;
    int          l3_ce_pulses = 0;

    alu_cmd_driver #(.WIDTH(8), .ALU_LAT(1), .TAG_W(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_opa(req_opa),
        .req_opb(req_opb), .req_cin(req_cin),
        .ALU_CE(alu_ce), .ALU_MODE(alu_mode), .ALU_CMD(alu_cmd),
        .ALU_INP_VALID(alu_inp_valid), .ALU_OPA(alu_opa), .ALU_OPB(alu_opb),
        .ALU_CIN(alu_cin), .ALU_RES(alu_res), .ALU_FLAGS(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .op_cnt(op_cnt), .err_cnt(err_cnt)
    );

    alu_cmd_driver #(.WIDTH(8), .ALU_LAT(3), .TAG_W(4), .CNT_W(16)) dut3 (
        .CLK(CLK), .RST(RST),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready), .req_mode(1'b1),
        .req_cmd(4'd0), .req_inp_valid(2'b11), .req_opa(l3_req_opa),
        .req_opb(8'h01), .req_cin(1'b0),
        .ALU_CE(l3_ce), .ALU_MODE(l3_mode), .ALU_CMD(l3_cmd),
        .ALU_INP_VALID(l3_inp_valid), .ALU_OPA(l3_opa), .ALU_OPB(l3_opb),
        .ALU_CIN(l3_cin), .ALU_RES(l3_s2[22:6]), .ALU_FLAGS(l3_s2[5:0]),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_res(l3_rsp_res),
        .rsp_flags(l3_rsp_flags), .rsp_tag(l3_rsp_tag),
        .op_cnt(l3_op_cnt), .err_cnt(l3_err_cnt)
    );

    // Behavioural ALU: ADD=0, CMP=8 in arithmetic mode; anything else or missing operands -> ERR.
    function automatic logic [22:0] alu_model(input logic mode, input logic [3:0] cmd,
                                              input logic [1:0] iv, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [16:0] r;
        logic [5:0]  f;
        r = '0;
        f = '0;
        if (iv != 2'b11) f[5] = 1'b1;
        else if (mode && cmd == 4'd0) begin
            r = {8'b0, {1'b0, a} + {1'b0, b}};
            f[3] = r[8];
        end else if (mode && cmd == 4'd8) begin
            f[2] = (a > b);
            f[1] = (a < b);
            f[0] = (a == b);
        end else f[5] = 1'b1;
        return {r, f};
    endfunction

    always @(posedge CLK) begin
        if (alu_ce) {alu_res, alu_flags} <= alu_model(alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb);
        if (l3_ce) l3_s0 <= alu_model(l3_mode, l3_cmd, l3_inp_valid, l3_opa, l3_opb);
        l3_s1 <= l3_s0;
        l3_s2 <= l3_s1;
        if (l3_ce) l3_ce_pulses <= l3_ce_pulses + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b);
        req_mode = mode; req_cmd = cmd; req_inp_valid = iv;
        req_opa = a; req_opb = b; req_cin = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        while (rsp_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (alu_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b want=0", alu_ce); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if ({rsp_res, rsp_flags} !== 23'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", {rsp_res, rsp_flags}); end
        total++; if ({op_cnt, err_cnt, rsp_tag} !== 36'h0) begin bad++; $display("FAIL reset_counters got=%h want=0", {op_cnt, err_cnt, rsp_tag}); end
        total++; if ({alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb, alu_cin} !== 24'h0) begin bad++; $display("FAIL reset_alu_regs got=%h want=0", {alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb, alu_cin}); end
        RST = 1'b0;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_carry();
        issue(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01);
        total++; if (alu_ce !== 1'b1) begin bad++; $display("FAIL carry_ce_pulse got=%b want=1", alu_ce); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL carry_ready_issue got=%b want=0", req_ready); end
        total++; if ({alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb} !== {1'b1, 4'd0, 2'b11, 8'hFF, 8'h01}) begin bad++; $display("FAIL carry_alu_latch got=%h", {alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb}); end
        tick();
        total++; if ({alu_ce, rsp_valid} !== 2'b00) begin bad++; $display("FAIL carry_wait got ce/valid=%b want=00", {alu_ce, rsp_valid}); end
        total++; if (alu_opa !== 8'hFF) begin bad++; $display("FAIL carry_alu_hold got=%h want=ff", alu_opa); end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL carry_valid_n2 got=%b want=1", rsp_valid); end
        total++; if (rsp_res !== 17'h100) begin bad++; $display("FAIL carry_res got=%h want=100", rsp_res); end
        total++; if (rsp_flags !== 6'b001000) begin bad++; $display("FAIL carry_flags got=%b want=001000", rsp_flags); end
        total++; if (rsp_tag !== 4'd0) begin bad++; $display("FAIL carry_tag got=%0d want=0", rsp_tag); end
        total++; if ({op_cnt, err_cnt} !== {16'd1, 16'd0}) begin bad++; $display("FAIL carry_cnts got=%0d/%0d want=1/0", op_cnt, err_cnt); end
        tick();
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL carry_handshake got valid/ready=%b want=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if ({rsp_valid, req_ready, alu_ce} !== 3'b100) begin bad++; $display("FAIL bp_ctrl_%0d got valid/ready/ce=%b want=100", k, {rsp_valid, req_ready, alu_ce}); end
            total++; if ({rsp_res, rsp_flags, rsp_tag} !== {17'h100, 6'b001000, 4'd1}) begin bad++; $display("FAIL bp_hold_%0d got=%h", k, {rsp_res, rsp_flags, rsp_tag}); end
        end
        rsp_ready = 1'b1;
        tick();
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got valid/ready=%b want=01", {rsp_valid, req_ready}); end
        total++; if (rsp_tag !== 4'd2) begin bad++; $display("FAIL bp_tag got=%0d want=2", rsp_tag); end
        total++; if (op_cnt !== 16'd2) begin bad++; $display("FAIL bp_opcnt got=%0d want=2", op_cnt); end
    endtask

    task automatic test_error();
        int edges;
        issue(1'b1, 4'd0, 2'b00, 8'h05, 8'h07);
        wait_rsp(edges);
        total++; if (rsp_valid !== 1'b1 || edges != 2) begin bad++; $display("FAIL err_latency got edges=%0d valid=%b want=2/1", edges, rsp_valid); end
        total++; if ({rsp_res, rsp_flags} !== {17'h0, 6'b100000}) begin bad++; $display("FAIL err_payload got=%h want res=0 flags=100000", {rsp_res, rsp_flags}); end
        total++; if ({op_cnt, err_cnt} !== {16'd3, 16'd1}) begin bad++; $display("FAIL err_cnts got=%0d/%0d want=3/1", op_cnt, err_cnt); end
        tick();
    endtask

    task automatic test_compare();
        int edges;
        issue(1'b1, 4'd8, 2'b11, 8'h10, 8'h20);
        wait_rsp(edges);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL cmp_timeout got valid=%b want=1", rsp_valid); end
        total++; if ({rsp_res, rsp_flags} !== {17'h0, 6'b000010}) begin bad++; $display("FAIL cmp_payload got=%h want res=0 flags=000010", {rsp_res, rsp_flags}); end
        total++; if ({op_cnt, err_cnt, rsp_tag} !== {16'd4, 16'd1, 4'd3}) begin bad++; $display("FAIL cmp_cnts got=%h want op=4 err=1 tag=3", {op_cnt, err_cnt, rsp_tag}); end
        tick();
    endtask

    task automatic test_mid_reset();
        int edges;
        int seen;
        l3_req_opa = 8'h20; l3_req_valid = 1'b1;
        tick();
        l3_req_valid = 1'b0;
        edges = 0;
        while (l3_rsp_valid !== 1'b1 && edges < 20) begin tick(); edges++; end
        tick();
        total++; if ({l3_op_cnt, l3_rsp_tag} !== {16'd1, 4'd1}) begin bad++; $display("FAIL mr_pre got op/tag=%h want 1/1", {l3_op_cnt, l3_rsp_tag}); end
        l3_req_opa = 8'h30; l3_req_valid = 1'b1;
        tick();
        l3_req_valid = 1'b0;
        tick();
        tick();
        #2 RST = 1'b1;
        #1;
        total++; if ({l3_ce, l3_rsp_valid, l3_req_ready} !== 3'b001) begin bad++; $display("FAIL mr_ctrl got ce/valid/ready=%b want=001", {l3_ce, l3_rsp_valid, l3_req_ready}); end
        total++; if ({l3_op_cnt, l3_err_cnt, l3_rsp_tag, l3_opa} !== 44'h0) begin bad++; $display("FAIL mr_clear got=%h want=0", {l3_op_cnt, l3_err_cnt, l3_rsp_tag, l3_opa}); end
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (l3_rsp_valid === 1'b1) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL mr_no_rsp got=%0d want=0", seen); end
    endtask

    task automatic test_latency_wrap();
        int edges;
        int ce_start;
        ce_start = l3_ce_pulses;
        for (int i = 0; i < 17; i++) begin
            l3_req_opa = 8'(i * 3); l3_req_valid = 1'b1;
            tick();
            l3_req_valid = 1'b0;
            edges = 0;
            while (l3_rsp_valid !== 1'b1 && edges < 20) begin tick(); edges++; end
            total++; if (l3_rsp_valid !== 1'b1 || edges != 4) begin bad++; $display("FAIL wrap_lat_%0d got edges=%0d want=4", i, edges); end
            total++; if (l3_rsp_tag !== 4'(i)) begin bad++; $display("FAIL wrap_tag_%0d got=%0d want=%0d", i, l3_rsp_tag, i % 16); end
            total++; if (l3_rsp_res !== 17'(i * 3 + 1)) begin bad++; $display("FAIL wrap_res_%0d got=%h want=%h", i, l3_rsp_res, i * 3 + 1); end
            tick();
        end
        total++; if (l3_ce_pulses - ce_start != 17) begin bad++; $display("FAIL wrap_ce_pulses got=%0d want=17", l3_ce_pulses - ce_start); end
        total++; if ({l3_op_cnt, l3_rsp_tag} !== {16'd17, 4'd1}) begin bad++; $display("FAIL wrap_final got op=%0d tag=%0d want 17/1", l3_op_cnt, l3_rsp_tag); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_backpressure();
        test_error();
        test_compare();
        test_mid_reset();
        test_latency_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
